accum_capture: RTL and testbench
================================

Name: accum_capture

Overview:
- Downstream consumer of the accumulator-FSM stage: watches its 16-bit `signal_out` stream, captures only value changes, and buffers them in a small FIFO.
- Drains to a valid/ready sink (logger or serializer).
- Counts and flags captures lost to back-pressure, so software can tell whether the recorded trace is complete.

Parameters:
- WIDTH, 16, data width of the sampled accumulator value.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- sample_in  input  WIDTH  accumulator value from the upstream FSM stage.
- sample_en  input  1  qualifies sample_in this cycle.
- flush  input  1  synchronous FIFO/change-detector clear.
- out_data  output  WIDTH  head-of-FIFO value.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  sink accepts out_data.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_count  output  CNT_W  captures lost because the FIFO was full; saturating.
- overflow  output  1  sticky; set on first drop.

Behaviour:
- Reset (rst=1 at clk edge):
  - level=0, out_valid=0, out_data=0.
  - drop_count=0, overflow=0.
  - prev register=0, prev_valid=0.
  - Reset wins over every other input, including mid-transfer; the entry in flight is discarded.
- Capture event: sample_en=1 and (prev_valid=0 or sample_in != prev).
  - On a capture event: prev<=sample_in, prev_valid<=1, even if the entry is then dropped.
  - sample_en=1 with an unchanged value causes no event and no push.
- Pop: out_valid && out_ready; advances the read pointer at the edge.
- Push: capture event and (level<DEPTH, or a pop occurs in the same cycle).
  - So full + pop + capture gives level unchanged, both accepted.
- Drop: capture event with level==DEPTH and no pop.
  - drop_count increments, holding at 2^CNT_W-1; overflow<=1.
  - FIFO contents are unchanged.
- Latency: a capture accepted at edge N is visible on out_data/out_valid after edge N (registered), if the FIFO was empty.
- out_data is the registered mem[rd_ptr] and is stable while out_valid=1 and out_ready=0. When out_valid=0, out_data holds its last value and is don't-care.
- Ordering: strict FIFO; no reordering or coalescing beyond change detection.
- flush=1:
  - level<=0, pointers<=0, prev_valid<=0; a same-cycle push and pop are both ignored.
  - drop_count and overflow are cleared only by rst.
- Pointers: $clog2(DEPTH)+1 bits, wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.
- Comparison is full WIDTH, unsigned; no arithmetic on data.

Decomposition:
- accum_capture_pkg: default WIDTH/DEPTH/CNT_W constants and a ptr-width localparam function.
- One sub-module, sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, level, rd_data).
- Change detector, drop counter and overflow flag stay in accum_capture.

Test Plan:
- Reset then idle: after rst, drive sample_en=0 for 10 cycles -> out_valid=0, level=0, drop_count=0, overflow=0.
- Change filtering: out_ready=1; sample_en=1 with sequence 5,5,7,7,7,0 -> out_data emits exactly 5,7,0, each one cycle after its first appearance.
- Fill and drop: out_ready=0, DEPTH=4; capture 1,2,3,4,5,6.
  - Response: level=4, drop_count=2, overflow=1.
  - Then out_ready=1 drains 1,2,3,4 in order.
- Full with simultaneous push/pop: FIFO full with 1..4; in one cycle out_ready=1 and capture 9.
  - Response: level stays 4, no drop, drain order 2,3,4,9.
- Flush mid-operation: 3 entries queued, flush=1 together with a capture of 8.
  - Response: next cycle level=0, out_valid=0, drop_count unchanged.
  - Re-presenting 8 afterwards is captured, because prev_valid was cleared.
- Counter saturation with CNT_W=2: force 5 drops -> drop_count=3 holds; rst mid-stream -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/accum_capture_pkg.sv
// Shared defaults and the pointer-width helper for the accumulator capture block.
package accum_capture_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/accum_capture_if.sv
// Sample stream in and valid/ready drain out of the capture block.
interface accum_capture_if
  import accum_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic [WIDTH-1:0] sample_in;
  logic             sample_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sample_in, sample_en, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  sample_in, sample_en, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/accum_capture_sync_fifo.sv
// Synchronous FIFO with a registered head; a push into an empty queue is
// forwarded so the entry is visible right after the accepting edge.
module sync_fifo
  import accum_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] level,
  output logic [WIDTH-1:0] rd_data
);
  localparam int AW = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = rd_data_reg;

  assign do_pop      = pop && !empty && !flush;
  assign do_push     = push && !flush && (!full || do_pop);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      // The new head is the incoming word only when nothing older remains queued.
      if (do_push && (empty || (do_pop && level == PTR_W'(1)))) begin
        rd_data_reg <= wr_data;
      end else if (do_pop && level > PTR_W'(1)) begin
        rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/accum_capture.sv
// Captures value changes of the accumulator stream into a FIFO and tracks
// captures lost while the FIFO was full and not draining.
module accum_capture
  import accum_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  accum_capture_if.slave   bus,
  output logic [PTR_W-1:0] level,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);
  logic [WIDTH-1:0] prev_reg;
  logic             prev_valid_reg;
  logic [CNT_W-1:0] drop_count_reg;
  logic             overflow_reg;
  logic             capture;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;

  assign capture = bus.sample_en && (!prev_valid_reg || (bus.sample_in != prev_reg));
  assign pop     = bus.out_valid && bus.out_ready;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (bus.sample_in),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .rd_data (bus.out_data)
  );

  assign bus.out_valid = !empty;
  assign drop_count    = drop_count_reg;
  assign overflow      = overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      // prev tracks every capture, including ones that end up dropped.
      if (capture) begin
        prev_reg <= bus.sample_in;
      end
      if (flush) begin
        prev_valid_reg <= 1'b0;
      end else if (capture) begin
        prev_valid_reg <= 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != '1) begin
          drop_count_reg <= drop_count_reg + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_accum_capture.sv
// Bench for accum_capture: directed tables and sequences plus random traffic
// checked against a queue-based model of the capture rules.
module tb_accum_capture;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [2:0]       level;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  accum_capture_if #(.WIDTH(WIDTH)) bus ();

  accum_capture #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .level      (level),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          mq[$];
  logic [15:0] m_prev;
  bit          m_pv;
  int          m_drop;
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit en, input logic [15:0] d, input bit rdy, input bit fl);
    bit pop;
    bit cap;
    rst           = r;
    bus.sample_en = en;
    bus.sample_in = d;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_prev = '0;
      m_pv   = 0;
      m_drop = 0;
      m_ovf  = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      cap = en && (!m_pv || d != m_prev);
      if (pop) $display("txn pop data=%0d", mq[0]);
      if (cap) m_prev = d;
      if (cap && mq.size() == DEPTH && !pop) begin
        m_ovf = 1;
        if (m_drop < CNT_MAX) m_drop++;
      end
      if (fl) begin
        mq.delete();
        m_pv = 0;
      end else begin
        if (cap) m_pv = 1;
        if (pop) void'(mq.pop_front());
        if (cap && mq.size() < DEPTH) mq.push_back(int'(d));
      end
    end
    chk("model_level", 32'(level), 32'(mq.size()));
    chk("model_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("model_data", 32'(bus.out_data), 32'(mq[0]));
    chk("model_drop", 32'(drop_count), 32'(m_drop));
    chk("model_ovf", 32'(overflow), 32'(m_ovf));
  endtask

  typedef struct {
    bit          en;
    logic [15:0] d;
    bit          rdy;
    bit          exp_valid;
    logic [15:0] exp_data;
    int          exp_level;
  } vec_t;

  vec_t tbl[7];
  int   exp_drain[4];

  initial begin
    tbl[0] = '{1, 16'd5, 1, 1, 16'd5, 1};
    tbl[1] = '{1, 16'd5, 1, 0, 16'd0, 0};
    tbl[2] = '{1, 16'd7, 1, 1, 16'd7, 1};
    tbl[3] = '{1, 16'd7, 1, 0, 16'd0, 0};
    tbl[4] = '{1, 16'd7, 1, 0, 16'd0, 0};
    tbl[5] = '{1, 16'd0, 1, 1, 16'd0, 1};
    tbl[6] = '{0, 16'd0, 1, 0, 16'd0, 0};

    // Reset then idle
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_drop", 32'(drop_count), 32'd0);
    chk("idle_ovf", 32'(overflow), 32'd0);

    // Change filtering from a table
    for (int i = 0; i < 7; i++) begin
      cycle(0, tbl[i].en, tbl[i].d, tbl[i].rdy, 0);
      chk("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].exp_valid));
      chk("tbl_level", 32'(level), 32'(tbl[i].exp_level));
      if (tbl[i].exp_valid) chk("tbl_data", 32'(bus.out_data), 32'(tbl[i].exp_data));
    end

    // Fill and drop
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) cycle(0, 1, 16'(i), 0, 0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_drop", 32'(drop_count), 32'd2);
    chk("fill_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_drain", 32'(bus.out_data), 32'(i));
      cycle(0, 0, 0, 1, 0);
    end
    chk("fill_empty", 32'(bus.out_valid), 32'd0);

    // Full with simultaneous push and pop
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 16'(i), 0, 0);
    cycle(0, 1, 16'd9, 1, 0);
    chk("fpp_level", 32'(level), 32'd4);
    chk("fpp_drop", 32'(drop_count), 32'd0);
    exp_drain = '{2, 3, 4, 9};
    for (int i = 0; i < 4; i++) begin
      chk("fpp_drain", 32'(bus.out_data), 32'(exp_drain[i]));
      cycle(0, 0, 0, 1, 0);
    end
    chk("fpp_empty", 32'(bus.out_valid), 32'd0);

    // Flush mid-operation
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cycle(0, 1, 16'(i), 0, 0);
    cycle(0, 1, 16'd8, 0, 1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_drop", 32'(drop_count), 32'd0);
    cycle(0, 1, 16'd8, 0, 0);
    chk("flush_recap_level", 32'(level), 32'd1);
    chk("flush_recap_data", 32'(bus.out_data), 32'd8);

    // Counter saturation, then reset mid-stream
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) cycle(0, 1, 16'(i), 0, 0);
    chk("sat_drop", 32'(drop_count), 32'(CNT_MAX));
    chk("sat_ovf", 32'(overflow), 32'd1);
    cycle(1, 1, 16'd10, 1, 0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_data", 32'(bus.out_data), 32'd0);
    chk("midrst_drop", 32'(drop_count), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 7),
            16'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
